// File: rtl/llc_set_reader_if.sv
// Bus bundle of the LLC set reader: lookup request, array read and write-snoop ports, result packet.
interface llc_set_reader_if #(
  parameter int WAYS    = 16,
  parameter int SET_W   = 9,
  parameter int TAG_W   = 20,
  parameter int LINE_W  = 128,
  parameter int STATE_W = 3,
  parameter int WAY_W   = $clog2(WAYS)
);
  logic                      req_valid;
  logic                      req_ready;
  logic [SET_W-1:0]          req_set;
  logic [TAG_W-1:0]          req_tag;
  logic                      rd_en;
  logic [SET_W-1:0]          rd_set;
  logic [WAYS*TAG_W-1:0]     rd_tags;
  logic [WAYS*STATE_W-1:0]   rd_states;
  logic [WAYS*LINE_W-1:0]    rd_lines;
  logic [WAY_W-1:0]          rd_evict_way;
  logic                      wr_en;
  logic [SET_W-1:0]          wr_set;
  logic [WAY_W-1:0]          wr_way;
  logic [TAG_W-1:0]          wr_data_tag;
  logic [STATE_W-1:0]        wr_data_state;
  logic [LINE_W-1:0]         wr_data_line;
  logic                      out_valid;
  logic                      out_ready;
  logic [WAYS*TAG_W-1:0]     out_tags;
  logic [WAYS*STATE_W-1:0]   out_states;
  logic [WAYS*LINE_W-1:0]    out_lines;
  logic                      out_hit;
  logic [WAY_W-1:0]          out_way;
  logic [WAY_W-1:0]          out_evict_way;

  modport slave (
    input  req_valid, req_set, req_tag, rd_tags, rd_states, rd_lines, rd_evict_way,
           wr_en, wr_set, wr_way, wr_data_tag, wr_data_state, wr_data_line, out_ready,
    output req_ready, rd_en, rd_set, out_valid, out_tags, out_states, out_lines,
           out_hit, out_way, out_evict_way
  );

  modport master (
    output req_valid, req_set, req_tag, rd_tags, rd_states, rd_lines, rd_evict_way,
           wr_en, wr_set, wr_way, wr_data_tag, wr_data_state, wr_data_line, out_ready,
    input  req_ready, rd_en, rd_set, out_valid, out_tags, out_states, out_lines,
           out_hit, out_way, out_evict_way
  );
endinterface

// File: rtl/llc_set_reader.sv
// LLC set reader: reads every way of one set, resolves hit/victim and presents one result packet.
// Macro LLC_SET_READER_BYPASS_EN forwards same-set array writes into the buffers instead of replaying the read.
module llc_set_reader #(
  parameter int WAYS    = 16,
  parameter int SET_W   = 9,
  parameter int TAG_W   = 20,
  parameter int LINE_W  = 128,
  parameter int STATE_W = 3,
  parameter int RD_LAT  = 1
) (
  input logic             clk,
  input logic             rst,
  llc_set_reader_if.slave bus
);
  localparam int WAY_W = $clog2(WAYS);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;
  localparam logic [1:0] FIX  = 2'd3;
  localparam logic [2:0] LAT  = 3'(RD_LAT);
`ifdef LLC_SET_READER_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [1:0]              state_r, state_nxt_s, fsm_s;
  logic [2:0]              cnt_r;
  logic [SET_W-1:0]        set_r, rd_set_s;
  logic [TAG_W-1:0]        tag_r;
  logic [WAYS*TAG_W-1:0]   tags_r, m_tags_s;
  logic [WAYS*STATE_W-1:0] states_r, m_states_s;
  logic [WAYS*LINE_W-1:0]  lines_r, m_lines_s;
  logic [WAY_W-1:0]        evict_r, m_evict_s, way_r;
  logic                    hit_r, valid_r;
  logic [WAYS-1:0]         fwd_r, wr_onehot_s;
  logic                    haz_s, hold_s, accept_s, replay_s, capture_s, recalc_s;
  logic                    fwd_new_s, fwd_s, req_ready_s, rd_en_s;
  logic [WAY_W:0]          look_s;

  // {hit, way}: lowest valid tag match, else lowest INVALID way, else the stored evict pointer.
  function automatic logic [WAY_W:0] lookup(input logic [WAYS*TAG_W-1:0] tags,
                                            input logic [WAYS*STATE_W-1:0] sts,
                                            input logic [TAG_W-1:0] tag,
                                            input logic [WAY_W-1:0] evict);
    logic             hit;
    logic [WAY_W-1:0] hway;
    logic [WAY_W-1:0] vway;
    hit  = 1'b0;
    hway = {WAY_W{1'b0}};
    vway = evict;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (sts[w*STATE_W +: STATE_W] != {STATE_W{1'b0}}) begin
        if (tags[w*TAG_W +: TAG_W] == tag) begin
          hit  = 1'b1;
          hway = WAY_W'(w);
        end else begin
        end
      end else begin
        vway = WAY_W'(w);
      end
    end
    return hit ? {1'b1, hway} : {1'b0, vway};
  endfunction

  assign haz_s       = bus.wr_en && (bus.wr_set == set_r) && (state_r != IDLE);
  // Without forwarding, a read racing a write to the same set could return pre-write data.
  assign hold_s      = !BYPASS && bus.wr_en && (bus.wr_set == bus.req_set);
  assign wr_onehot_s = {{(WAYS-1){1'b0}}, 1'b1} << bus.wr_way;
  assign fwd_new_s   = BYPASS && accept_s && bus.wr_en && (bus.wr_set == bus.req_set);
  assign fwd_s       = accept_s ? fwd_new_s : (BYPASS && haz_s);
  assign recalc_s    = capture_s || (state_r == FIX);
  assign look_s      = lookup(m_tags_s, m_states_s, tag_r, m_evict_s);

  // Next state, request acceptance and the array read strobe.
  always_comb begin
    req_ready_s = 1'b0;
    replay_s    = 1'b0;
    capture_s   = 1'b0;
    fsm_s       = state_r;
    case (state_r)
      IDLE: req_ready_s = !hold_s;
      WAIT: begin
        if (haz_s && !BYPASS) begin
          replay_s = 1'b1;
        end else if (cnt_r == 3'd1) begin
          capture_s = 1'b1;
          fsm_s     = OUT;
        end else begin
          fsm_s = WAIT;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          req_ready_s = !hold_s;
          fsm_s       = IDLE;
        end else if (haz_s) begin
          if (BYPASS) begin
            fsm_s = FIX;
          end else begin
            replay_s = 1'b1;
          end
        end else begin
          fsm_s = OUT;
        end
      end
      FIX:     fsm_s = haz_s ? FIX : OUT;
      default: fsm_s = IDLE;
    endcase
    accept_s    = req_ready_s && bus.req_valid;
    rd_en_s     = accept_s || replay_s;
    rd_set_s    = replay_s ? set_r : bus.req_set;
    state_nxt_s = rd_en_s ? WAIT : fsm_s;
  end

  // Buffer contents for this edge: array data at capture unless a way was already forwarded; write data wins.
  always_comb begin
    m_tags_s   = tags_r;
    m_states_s = states_r;
    m_lines_s  = lines_r;
    m_evict_s  = capture_s ? bus.rd_evict_way : evict_r;
    for (int w = 0; w < WAYS; w++) begin
      if (capture_s && !fwd_r[w]) begin
        m_tags_s[w*TAG_W +: TAG_W]       = bus.rd_tags[w*TAG_W +: TAG_W];
        m_states_s[w*STATE_W +: STATE_W] = bus.rd_states[w*STATE_W +: STATE_W];
        m_lines_s[w*LINE_W +: LINE_W]    = bus.rd_lines[w*LINE_W +: LINE_W];
      end else begin
      end
      if (fwd_s && wr_onehot_s[w]) begin
        m_tags_s[w*TAG_W +: TAG_W]       = bus.wr_data_tag;
        m_states_s[w*STATE_W +: STATE_W] = bus.wr_data_state;
        m_lines_s[w*LINE_W +: LINE_W]    = bus.wr_data_line;
      end else begin
      end
    end
  end

  // State, latched request, latency counter, buffers and the registered result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= IDLE;
      valid_r  <= 1'b0;
      cnt_r    <= 3'd0;
      set_r    <= {SET_W{1'b0}};
      tag_r    <= {TAG_W{1'b0}};
      tags_r   <= {(WAYS*TAG_W){1'b0}};
      states_r <= {(WAYS*STATE_W){1'b0}};
      lines_r  <= {(WAYS*LINE_W){1'b0}};
      evict_r  <= {WAY_W{1'b0}};
      fwd_r    <= {WAYS{1'b0}};
      hit_r    <= 1'b0;
      way_r    <= {WAY_W{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      valid_r  <= (state_nxt_s == OUT);
      tags_r   <= m_tags_s;
      states_r <= m_states_s;
      lines_r  <= m_lines_s;
      evict_r  <= m_evict_s;
      if (accept_s) begin
        set_r <= bus.req_set;
        tag_r <= bus.req_tag;
        cnt_r <= LAT;
      end else if (replay_s) begin
        cnt_r <= LAT;
      end else if (state_r == WAIT) begin
        cnt_r <= cnt_r - 3'd1;
      end else begin
        cnt_r <= cnt_r;
      end
      if (accept_s) begin
        fwd_r <= fwd_new_s ? wr_onehot_s : {WAYS{1'b0}};
      end else if (fwd_s) begin
        fwd_r <= fwd_r | wr_onehot_s;
      end else begin
        fwd_r <= fwd_r;
      end
      if (recalc_s) begin
        {hit_r, way_r} <= look_s;
      end else begin
        {hit_r, way_r} <= {hit_r, way_r};
      end
    end
  end

  assign bus.req_ready     = req_ready_s;
  assign bus.rd_en         = rd_en_s;
  assign bus.rd_set        = rd_set_s;
  assign bus.out_valid     = valid_r;
  assign bus.out_tags      = tags_r;
  assign bus.out_states    = states_r;
  assign bus.out_lines     = lines_r;
  assign bus.out_hit       = hit_r;
  assign bus.out_way       = way_r;
  assign bus.out_evict_way = evict_r;
endmodule

// File: tb/tb_llc_set_reader.sv
// Directed bench for llc_set_reader: instance a with RD_LAT=1, instance b with RD_LAT=3.
module tb_llc_set_reader;
  localparam int WAYS = 16, SET_W = 9, TAG_W = 20, LINE_W = 128, STATE_W = 3, WAY_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [WAYS*TAG_W-1:0]   tags_v;
  logic [WAYS*STATE_W-1:0] states_v;
  logic [WAYS*LINE_W-1:0]  lines_v;

  always #5 clk = ~clk;

  llc_set_reader_if #(.WAYS(WAYS), .SET_W(SET_W), .TAG_W(TAG_W), .LINE_W(LINE_W), .STATE_W(STATE_W)) ia ();
  llc_set_reader_if #(.WAYS(WAYS), .SET_W(SET_W), .TAG_W(TAG_W), .LINE_W(LINE_W), .STATE_W(STATE_W)) ib ();

  llc_set_reader #(.WAYS(WAYS), .SET_W(SET_W), .TAG_W(TAG_W), .LINE_W(LINE_W), .STATE_W(STATE_W),
                   .RD_LAT(1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  llc_set_reader #(.WAYS(WAYS), .SET_W(SET_W), .TAG_W(TAG_W), .LINE_W(LINE_W), .STATE_W(STATE_W),
                   .RD_LAT(3)) dut_b (.clk(clk), .rst(rst), .bus(ib));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WAY_W-1:0] evict);
    ia.rd_tags = tags_v; ia.rd_states = states_v; ia.rd_lines = lines_v; ia.rd_evict_way = evict;
    ib.rd_tags = tags_v; ib.rd_states = states_v; ib.rd_lines = lines_v; ib.rd_evict_way = evict;
  endtask

  // Default array contents: every way valid, tag 0x100+way, line 0xC0DE0000+way.
  task automatic fill_array(input logic [WAY_W-1:0] evict);
    for (int w = 0; w < WAYS; w++) begin
      tags_v[w*TAG_W +: TAG_W]       = TAG_W'(256 + w);
      states_v[w*STATE_W +: STATE_W] = 3'd1;
      lines_v[w*LINE_W +: LINE_W]    = LINE_W'(32'hC0DE_0000 + w);
    end
    push(evict);
  endtask

  task automatic consume_a();
    ia.out_ready = 1'b1;
    step();
    ia.out_ready = 1'b0;
  endtask

  initial begin
    ia.req_valid = 1'b0; ia.req_set = '0; ia.req_tag = '0; ia.out_ready = 1'b0;
    ia.wr_en = 1'b0; ia.wr_set = '0; ia.wr_way = '0; ia.wr_data_tag = '0;
    ia.wr_data_state = '0; ia.wr_data_line = '0;
    ib.req_valid = 1'b0; ib.req_set = '0; ib.req_tag = '0; ib.out_ready = 1'b0;
    ib.wr_en = 1'b0; ib.wr_set = '0; ib.wr_way = '0; ib.wr_data_tag = '0;
    ib.wr_data_state = '0; ib.wr_data_line = '0;
    fill_array(4'd0);
    step();
    step();
    chk("rst_req_ready", ia.req_ready, 1);
    chk("rst_rd_en", ia.rd_en, 0);
    chk("rst_out_valid", ia.out_valid, 0);
    chk("rst_out_hit", ia.out_hit, 0);
    chk("rst_out_way", ia.out_way, 0);
    chk("rst_out_evict", ia.out_evict_way, 0);
    chk("rst_out_tags", ia.out_tags[127:0], 0);
    chk("rst_b_out_valid", ib.out_valid, 0);

    // Hit in way 3 of set 5
    rst = 1'b1;
    tags_v[3*TAG_W +: TAG_W] = 20'hABC;
    push(4'd0);
    ia.req_valid = 1'b1; ia.req_set = 9'd5; ia.req_tag = 20'hABC;
    #1;
    chk("hit_rd_en", ia.rd_en, 1);
    chk("hit_rd_set", ia.rd_set, 5);
    chk("hit_req_ready", ia.req_ready, 1);
    step();
    ia.req_valid = 1'b0;
    #1;
    chk("hit_rd_en_pulse", ia.rd_en, 0);
    chk("hit_wait_ready", ia.req_ready, 0);
    chk("hit_wait_valid", ia.out_valid, 0);
    step();
    chk("hit_valid", ia.out_valid, 1);
    chk("hit_hit", ia.out_hit, 1);
    chk("hit_way", ia.out_way, 3);
    chk("hit_tag3", ia.out_tags[3*TAG_W +: TAG_W], 20'hABC);
    chk("hit_line3", ia.out_lines[3*LINE_W +: LINE_W], 32'hC0DE_0003);

    // Stall: array inputs change, outputs must not
    tags_v[3*TAG_W +: TAG_W] = 20'h0;
    push(4'd9);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", ia.out_valid, 1);
      chk("stall_way", ia.out_way, 3);
      chk("stall_tag3", ia.out_tags[3*TAG_W +: TAG_W], 20'hABC);
      chk("stall_req_ready", ia.req_ready, 0);
    end

    // Back-to-back into a miss with full set, victim from evict pointer 7
    fill_array(4'd7);
    ia.out_ready = 1'b1; ia.req_valid = 1'b1; ia.req_set = 9'd6; ia.req_tag = 20'h55;
    #1;
    chk("b2b_req_ready", ia.req_ready, 1);
    chk("b2b_rd_en", ia.rd_en, 1);
    chk("b2b_rd_set", ia.rd_set, 6);
    step();
    ia.out_ready = 1'b0; ia.req_valid = 1'b0;
    #1;
    chk("b2b_wait_valid", ia.out_valid, 0);
    step();
    chk("miss_valid", ia.out_valid, 1);
    chk("miss_hit", ia.out_hit, 0);
    chk("miss_way", ia.out_way, 7);
    chk("miss_evict", ia.out_evict_way, 7);
    consume_a();
    #1;
    chk("idle_valid", ia.out_valid, 0);
    chk("idle_req_ready", ia.req_ready, 1);

    // Ways 2 and 9 INVALID: lowest invalid way is the victim
    states_v[2*STATE_W +: STATE_W] = 3'd0;
    states_v[9*STATE_W +: STATE_W] = 3'd0;
    push(4'd7);
    ia.req_valid = 1'b1; ia.req_set = 9'd6; ia.req_tag = 20'h55;
    step();
    ia.req_valid = 1'b0;
    step();
    chk("inv_valid", ia.out_valid, 1);
    chk("inv_hit", ia.out_hit, 0);
    chk("inv_way", ia.out_way, 2);
    consume_a();

    // Same-set write to way 4 while the result is held
    fill_array(4'd0);
    ia.req_valid = 1'b1; ia.req_set = 9'd8; ia.req_tag = 20'h777;
    step();
    ia.req_valid = 1'b0;
    step();
    chk("wr_pre_hit", ia.out_hit, 0);
    chk("wr_pre_way", ia.out_way, 0);
    ia.wr_en = 1'b1; ia.wr_set = 9'd8; ia.wr_way = 4'd4;
    ia.wr_data_tag = 20'h777; ia.wr_data_state = 3'd1; ia.wr_data_line = 128'hBEEF;
    #1;
`ifdef LLC_SET_READER_BYPASS_EN
    chk("byp_no_rd_en", ia.rd_en, 0);
    step();
    ia.wr_en = 1'b0;
    #1;
    chk("byp_drop_valid", ia.out_valid, 0);
    step();
    chk("byp_tag4", ia.out_tags[4*TAG_W +: TAG_W], 20'h777);
    chk("byp_line4", ia.out_lines[4*LINE_W +: LINE_W], 128'hBEEF);
`else
    chk("rep_rd_en", ia.rd_en, 1);
    chk("rep_rd_set", ia.rd_set, 8);
    step();
    ia.wr_en = 1'b0;
    tags_v[4*TAG_W +: TAG_W] = 20'h777;
    push(4'd0);
    #1;
    chk("rep_drop_valid", ia.out_valid, 0);
    step();
`endif
    chk("wr_valid", ia.out_valid, 1);
    chk("wr_hit", ia.out_hit, 1);
    chk("wr_way", ia.out_way, 4);
    consume_a();

    // Write to another set during WAIT has no effect
    fill_array(4'd0);
    ia.req_valid = 1'b1; ia.req_set = 9'd10; ia.req_tag = 20'h105;
    step();
    ia.req_valid = 1'b0;
    ia.wr_en = 1'b1; ia.wr_set = 9'd11; ia.wr_way = 4'd5;
    ia.wr_data_tag = 20'hFFF; ia.wr_data_state = 3'd0;
    #1;
    chk("other_no_rd_en", ia.rd_en, 0);
    step();
    ia.wr_en = 1'b0;
    chk("other_valid", ia.out_valid, 1);
    chk("other_hit", ia.out_hit, 1);
    chk("other_way", ia.out_way, 5);
    chk("other_tag5", ia.out_tags[5*TAG_W +: TAG_W], 20'h105);
    consume_a();

    // Request colliding with a same-set write in IDLE
    fill_array(4'd0);
    ia.req_valid = 1'b1; ia.req_set = 9'd12; ia.req_tag = 20'h222;
    ia.wr_en = 1'b1; ia.wr_set = 9'd12; ia.wr_way = 4'd1;
    ia.wr_data_tag = 20'h222; ia.wr_data_state = 3'd1;
    #1;
`ifdef LLC_SET_READER_BYPASS_EN
    chk("col_req_ready", ia.req_ready, 1);
    chk("col_rd_en", ia.rd_en, 1);
    step();
    ia.wr_en = 1'b0; ia.req_valid = 1'b0;
`else
    chk("col_hold_ready", ia.req_ready, 0);
    chk("col_hold_rd_en", ia.rd_en, 0);
    step();
    ia.wr_en = 1'b0;
    tags_v[1*TAG_W +: TAG_W] = 20'h222;
    push(4'd0);
    #1;
    chk("col_req_ready", ia.req_ready, 1);
    chk("col_rd_en", ia.rd_en, 1);
    step();
    ia.req_valid = 1'b0;
`endif
    step();
    chk("col_valid", ia.out_valid, 1);
    chk("col_hit", ia.out_hit, 1);
    chk("col_way", ia.out_way, 1);
    consume_a();

    // RD_LAT=3: result four cycles after the request
    fill_array(4'd0);
    ib.req_valid = 1'b1; ib.req_set = 9'd3; ib.req_tag = 20'h103;
    #1;
    chk("lat3_rd_en", ib.rd_en, 1);
    step();
    ib.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("lat3_wait_valid", ib.out_valid, 0);
      step();
    end
    chk("lat3_valid", ib.out_valid, 1);
    chk("lat3_hit", ib.out_hit, 1);
    chk("lat3_way", ib.out_way, 3);
    ib.out_ready = 1'b1;
    step();
    ib.out_ready = 1'b0;

    // Reset in the middle of WAIT abandons the read
    ib.req_valid = 1'b1; ib.req_set = 9'd4; ib.req_tag = 20'h104;
    step();
    ib.req_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("mid_rst_valid", ib.out_valid, 0);
    chk("mid_rst_ready", ib.req_ready, 1);
    chk("mid_rst_rd_en", ib.rd_en, 0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_rst_late_valid", ib.out_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/llc_set_reader.md
Name: llc_set_reader

Overview:
- Read-side counterpart of the LLC array write port.
- Accepts a set-lookup request, reads every way of that set from the tag/state/line/evict-way arrays, and captures the result into per-way buffers.
- Computes hit/miss, hit way and victim way, then presents one result packet to the LLC pipeline with a valid/ready handshake.
- Snoops the array write port so the buffered set is never stale.

Parameters:
- WAYS, 16, ways per set; power of two, ≥2.
- SET_W, 9, set index width.
- TAG_W, 20, tag width.
- LINE_W, 128, line width.
- STATE_W, 3, state width; INVALID is encoded 0.
- RD_LAT, 1, array read latency in cycles, 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active low.
- req_valid  in  1  lookup request valid.
- req_ready  out  1  block can accept a request.
- req_set  in  SET_W  set to read.
- req_tag  in  TAG_W  tag to match.
- rd_en  out  1  array read strobe.
- rd_set  out  SET_W  array read index.
- rd_tags  in  WAYS*TAG_W  tags, way 0 in the LSBs.
- rd_states  in  WAYS*STATE_W  states.
- rd_lines  in  WAYS*LINE_W  lines.
- rd_evict_way  in  log2(WAYS)  stored round-robin victim pointer.
- wr_en  in  1  array write strobe from the update stage.
- wr_set  in  SET_W  set written.
- wr_way  in  log2(WAYS)  way written.
- wr_data_tag  in  TAG_W  write tag.
- wr_data_state  in  STATE_W  write state.
- wr_data_line  in  LINE_W  write line.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_tags  out  WAYS*TAG_W  buffered tags.
- out_states  out  WAYS*STATE_W  buffered states.
- out_lines  out  WAYS*LINE_W  buffered lines.
- out_hit  out  1  tag matched in a non-INVALID way.
- out_way  out  log2(WAYS)  hit way if hit, else victim way.
- out_evict_way  out  log2(WAYS)  captured evict pointer.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE.
  - Outputs: req_ready=1, rd_en=0, out_valid=0.
  - All buffers, out_hit, out_way and out_evict_way cleared to 0.
  - Any in-flight read is abandoned; late array data is ignored.
- FSM IDLE:
  - req_ready=1.
  - On req_valid, drive rd_en=1 and rd_set=req_set combinationally in that cycle.
  - Latch set and tag, load the latency counter with RD_LAT, go to WAIT.
- FSM WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - When the counter reaches 1, sample the rd_* inputs into the buffers at that clock edge and go to OUT.
  - Request-to-out_valid latency is therefore RD_LAT+1 cycles.
- FSM OUT:
  - out_valid=1 and all out_* held stable until out_ready.
  - On out_valid&&out_ready, if req_valid is also high, the new request is accepted in the same cycle (back-to-back): rd_en=1 and go to WAIT. Otherwise go to IDLE.
  - req_ready = IDLE || (OUT && out_ready).
- Hit/victim (computed from the buffered data in the capture cycle, registered):
  - Hit: the lowest-index way with state!=0 and tag==latched tag.
  - Victim: the lowest-index way with state==0; if none, rd_evict_way.
  - out_hit=0 when no way matches.
- Write hazard:
  - Any wr_en with wr_set==latched set while in WAIT or OUT is a hazard on the buffered set.
  - Handling of the hazard is defined under Optional Feature.
  - Writes to other sets are ignored.

Optional Feature:
- Macro: LLC_SET_READER_BYPASS_EN.
- Defined (forwarding):
  - A same-set write overwrites buffer entry wr_way with the wr_data_* values.
  - In the capture cycle, the write data takes priority over the rd_* data for that way.
  - out_hit and out_way are recomputed the following cycle.
  - out_valid drops for that one cycle only.
- Undefined (replay):
  - A same-set write in WAIT or OUT drops out_valid and replays the read: rd_en=1 for the latched set and a return to WAIT.
  - In IDLE, a request whose req_set equals wr_set while wr_en=1 is held: req_ready=0 that cycle.

Test Plan:
- Reset then request set 5, tag 0xABC, with way 3 valid and matching, RD_LAT=1 → rd_en pulse one cycle, out_valid two cycles later, out_hit=1, out_way=3.
- Set with all ways valid, no tag match, rd_evict_way=7 → out_hit=0, out_way=7. Same set with ways 2 and 9 INVALID → out_way=2.
- out_ready held low 5 cycles → outputs stable, req_ready=0. Then out_ready=1 with req_valid=1 → new rd_en in the same cycle, next result RD_LAT+1 cycles later.
- Write during OUT, wr_set=latched set, wr_way=4, state=VALID, matching tag:
  - Bypass: out_hit=1, out_way=4 after the one-cycle valid drop.
  - Replay: a second rd_en is observed.
- Write to a different set during WAIT → no effect on the result.
- rst=0 asserted mid-WAIT with RD_LAT=3 → next cycle out_valid=0, req_ready=1; the late array data is never presented.
